// File: rtl/airi5c_sign_minmax_pkg.sv
// Shared FPU definitions: format widths, canonical NaNs, FCLASS bit
// positions and the min/max compare FSM state type.
package airi5c_fpu_pkg;

  localparam int EXP_W_32 = 8;
  localparam int EXP_W_64 = 11;
  localparam int MAN_W_32 = 23;
  localparam int MAN_W_64 = 52;

  // Exponent width for a given operand width (32 -> 8, 64 -> 11).
  function automatic int exp_w(input int flen);
    return (flen == 64) ? EXP_W_64 : EXP_W_32;
  endfunction

  // Stored mantissa width for a given operand width.
  function automatic int man_w(input int flen);
    return (flen == 64) ? MAN_W_64 : MAN_W_32;
  endfunction

  localparam logic [31:0] CANON_NAN_32 = 32'h7FC0_0000;
  localparam logic [63:0] CANON_NAN_64 = 64'h7FF8_0000_0000_0000;

  localparam int FCLASS_W    = 10;
  localparam int FC_NEG_INF  = 0;
  localparam int FC_NEG_NORM = 1;
  localparam int FC_NEG_SUB  = 2;
  localparam int FC_NEG_ZERO = 3;
  localparam int FC_POS_ZERO = 4;
  localparam int FC_POS_SUB  = 5;
  localparam int FC_POS_NORM = 6;
  localparam int FC_POS_INF  = 7;
  localparam int FC_SNAN     = 8;
  localparam int FC_QNAN     = 9;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

endpackage

// File: rtl/airi5c_sign_minmax_if.sv
// Request/response bundle between the FPU issue logic and the
// sign-manipulation / min-max unit.
//
// Handshake: the master raises load together with exactly the op it wants
// (extra ops resolve by fixed priority) while busy=0; the unit answers with a
// one-cycle ready pulse, and float_out/nv are valid while ready=1. A load seen
// while busy=1 is dropped, so the master must hold the request until busy
// falls. kill aborts anything in flight and suppresses its ready pulse.
// state mirrors the internal compare FSM for observation only.
interface airi5c_sign_minmax_if #(
  parameter int FLEN = 32
);
  logic                    kill;
  logic                    load;
  logic                    op_sgnj;
  logic                    op_sgnjn;
  logic                    op_sgnjx;
  logic                    op_min;
  logic                    op_max;
  logic                    op_class;
  logic [FLEN-1:0]         a;
  logic [FLEN-1:0]         b;
  logic [FLEN-1:0]         float_out;
  logic                    nv;
  logic                    ready;
  logic                    busy;
  airi5c_fpu_pkg::state_t  state;

  modport master (
    output kill, load, op_sgnj, op_sgnjn, op_sgnjx, op_min, op_max, op_class, a, b,
    input  float_out, nv, ready, busy, state
  );

  modport slave (
    input  kill, load, op_sgnj, op_sgnjn, op_sgnjx, op_min, op_max, op_class, a, b,
    output float_out, nv, ready, busy, state
  );
endinterface

// File: rtl/airi5c_sign_minmax_classify.sv
// Combinational IEEE-754 operand classifier (airi5c_fp_classify), width set
// by FLEN (32 or 64).
module airi5c_fp_classify
  import airi5c_fpu_pkg::*;
#(
  parameter int FLEN = 32
) (
  input  logic [FLEN-1:0] a,
  output logic            is_zero,
  output logic            is_sub,
  output logic            is_inf,
  output logic            is_snan,
  output logic            is_qnan,
  output logic            sign
);
  localparam int EXP_W = exp_w(FLEN);
  localparam int MAN_W = man_w(FLEN);

  logic [EXP_W-1:0] exponent;
  logic [MAN_W-1:0] mantissa;
  logic             exp_ones;
  logic             exp_zero;
  logic             man_zero;

  assign exponent = a[FLEN-2 -: EXP_W];
  assign mantissa = a[MAN_W-1:0];
  assign exp_ones = &exponent;
  assign exp_zero = ~|exponent;
  assign man_zero = ~|mantissa;

  assign sign    = a[FLEN-1];
  assign is_zero = exp_zero & man_zero;
  assign is_sub  = exp_zero & ~man_zero;
  assign is_inf  = exp_ones & man_zero;
  // The top mantissa bit is the quiet bit; a NaN without it is signalling.
  assign is_snan = exp_ones & ~man_zero & ~mantissa[MAN_W-1];
  assign is_qnan = exp_ones & mantissa[MAN_W-1];
endmodule

// File: rtl/airi5c_sign_minmax.sv
// FPU sign injection (FSGNJ/FSGNJN/FSGNJX) and FMIN/FMAX unit.
// Sign ops finish one edge after load; min/max registers its operands and
// resolves in the CMP state one edge later.
// Optional: AIRI5C_FPU_FCLASS_EN enables the single-cycle FCLASS op.
module airi5c_sign_minmax
  import airi5c_fpu_pkg::*;
#(
  parameter int FLEN = 32
) (
  input logic                  clk,
  input logic                  n_reset,
  airi5c_sign_minmax_if.slave  bus
);
  if (FLEN != 32 && FLEN != 64) begin : g_bad_flen
    $error("airi5c_sign_minmax: FLEN must be 32 or 64");
  end

  localparam logic [63:0]     CANON_WIDE = (FLEN == 32) ? {32'h0, CANON_NAN_32} : CANON_NAN_64;
  localparam logic [FLEN-1:0] CANON_NAN  = CANON_WIDE[FLEN-1:0];

  state_t          state, state_nxt;
  logic [FLEN-1:0] float_q, float_nxt;
  logic [FLEN-1:0] a_q, a_q_nxt;
  logic [FLEN-1:0] b_q, b_q_nxt;
  logic            min_q, min_q_nxt;
  logic            nv_q, nv_nxt;
  logic            ready_q, ready_nxt;
  logic            busy_q, busy_nxt;

  // Operand A is classified from the live input while idle (FCLASS) and from
  // the captured operand during the compare; B is only ever needed captured.
  logic [FLEN-1:0] cls_a_in;
  logic a_zero, a_sub, a_inf, a_snan, a_qnan, a_sign;
  logic b_zero, b_sub, b_inf, b_snan, b_qnan, b_sign;

  assign cls_a_in = (state == CMP) ? a_q : bus.a;

  airi5c_fp_classify #(.FLEN(FLEN)) u_cls_a (
    .a(cls_a_in), .is_zero(a_zero), .is_sub(a_sub), .is_inf(a_inf),
    .is_snan(a_snan), .is_qnan(a_qnan), .sign(a_sign)
  );

  airi5c_fp_classify #(.FLEN(FLEN)) u_cls_b (
    .a(b_q), .is_zero(b_zero), .is_sub(b_sub), .is_inf(b_inf),
    .is_snan(b_snan), .is_qnan(b_qnan), .sign(b_sign)
  );

  logic a_nan, b_nan, a_lt_b, mm_nv;
  logic [FLEN-1:0] mm_result;

  assign a_nan = a_snan | a_qnan;
  assign b_nan = b_snan | b_qnan;
  assign mm_nv = a_snan | b_snan;

  // Sign-magnitude ordering; differing signs put -0 below +0 for free.
  always_comb begin
    a_lt_b = 1'b0;
    if (a_sign != b_sign) a_lt_b = a_sign;
    else if (!a_sign)     a_lt_b = (a_q[FLEN-2:0] < b_q[FLEN-2:0]);
    else                  a_lt_b = (a_q[FLEN-2:0] > b_q[FLEN-2:0]);
  end

  // Pick the min/max result, letting a lone NaN lose to the other operand.
  always_comb begin
    mm_result = a_q;
    if (a_nan && b_nan) mm_result = CANON_NAN;
    else if (a_nan)     mm_result = b_q;
    else if (b_nan)     mm_result = a_q;
    else if (min_q)     mm_result = a_lt_b ? a_q : b_q;
    else                mm_result = a_lt_b ? b_q : a_q;
  end

  logic unused_flags;
`ifdef AIRI5C_FPU_FCLASS_EN
  logic                a_norm;
  logic [FCLASS_W-1:0] class_vec;

  assign a_norm = ~(a_zero | a_sub | a_inf | a_snan | a_qnan);

  // One-hot FCLASS encoding of the live operand A.
  always_comb begin
    class_vec              = '0;
    class_vec[FC_NEG_INF]  = a_sign & a_inf;
    class_vec[FC_NEG_NORM] = a_sign & a_norm;
    class_vec[FC_NEG_SUB]  = a_sign & a_sub;
    class_vec[FC_NEG_ZERO] = a_sign & a_zero;
    class_vec[FC_POS_ZERO] = ~a_sign & a_zero;
    class_vec[FC_POS_SUB]  = ~a_sign & a_sub;
    class_vec[FC_POS_NORM] = ~a_sign & a_norm;
    class_vec[FC_POS_INF]  = ~a_sign & a_inf;
    class_vec[FC_SNAN]     = a_snan;
    class_vec[FC_QNAN]     = a_qnan;
  end

  assign unused_flags = ^{b_zero, b_sub, b_inf};
`else
  assign unused_flags = ^{b_zero, b_sub, b_inf, a_zero, a_sub, a_inf, bus.op_class};
`endif

  // Next-state and result selection: kill, then CMP completion, then load decode.
  always_comb begin
    state_nxt = state;
    float_nxt = float_q;
    nv_nxt    = nv_q;
    ready_nxt = 1'b0;
    busy_nxt  = busy_q;
    a_q_nxt   = a_q;
    b_q_nxt   = b_q;
    min_q_nxt = min_q;
    if (bus.kill) begin
      state_nxt = IDLE;
      float_nxt = '0;
      nv_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else if (state == CMP) begin
      // Any load presented here is dropped; the compare always completes.
      state_nxt = IDLE;
      float_nxt = mm_result;
      nv_nxt    = mm_nv;
      ready_nxt = 1'b1;
      busy_nxt  = 1'b0;
    end else if (bus.load) begin
      if (bus.op_sgnj) begin
        float_nxt = {bus.b[FLEN-1], bus.a[FLEN-2:0]};
        nv_nxt    = 1'b0;
        ready_nxt = 1'b1;
      end else if (bus.op_sgnjn) begin
        float_nxt = {~bus.b[FLEN-1], bus.a[FLEN-2:0]};
        nv_nxt    = 1'b0;
        ready_nxt = 1'b1;
      end else if (bus.op_sgnjx) begin
        float_nxt = {bus.a[FLEN-1] ^ bus.b[FLEN-1], bus.a[FLEN-2:0]};
        nv_nxt    = 1'b0;
        ready_nxt = 1'b1;
      end else if (bus.op_min || bus.op_max) begin
        a_q_nxt   = bus.a;
        b_q_nxt   = bus.b;
        min_q_nxt = bus.op_min;
        state_nxt = CMP;
        busy_nxt  = 1'b1;
`ifdef AIRI5C_FPU_FCLASS_EN
      end else if (bus.op_class) begin
        float_nxt = {{(FLEN-FCLASS_W){1'b0}}, class_vec};
        nv_nxt    = 1'b0;
        ready_nxt = 1'b1;
`endif
      end else begin
        float_nxt = '0;
        nv_nxt    = 1'b0;
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      float_q <= '0;
      nv_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      min_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      float_q <= float_nxt;
      nv_q    <= nv_nxt;
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
      a_q     <= a_q_nxt;
      b_q     <= b_q_nxt;
      min_q   <= min_q_nxt;
    end
  end

  assign bus.float_out = float_q;
  assign bus.nv        = nv_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.state     = state;
endmodule

// File: tb/tb_airi5c_sign_minmax.sv
// Bench for airi5c_sign_minmax: one FLEN=32 and one FLEN=64 instance driven
// with directed vectors; expected {nv, result} pairs are queued at issue and
// popped by per-instance monitors on every ready pulse.
// Build with AIRI5C_FPU_FCLASS_EN defined to exercise FCLASS.
module tb_airi5c_sign_minmax;
  import airi5c_fpu_pkg::*;

  localparam logic [5:0] OP_NONE  = 6'b000000;
  localparam logic [5:0] OP_SGNJ  = 6'b000001;
  localparam logic [5:0] OP_SGNJN = 6'b000010;
  localparam logic [5:0] OP_SGNJX = 6'b000100;
  localparam logic [5:0] OP_MIN   = 6'b001000;
  localparam logic [5:0] OP_MAX   = 6'b010000;
  localparam logic [5:0] OP_CLASS = 6'b100000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  airi5c_sign_minmax_if #(.FLEN(32)) bus32();
  airi5c_sign_minmax_if #(.FLEN(64)) bus64();

  airi5c_sign_minmax #(.FLEN(32)) dut32 (.clk(clk), .n_reset(n_reset), .bus(bus32));
  airi5c_sign_minmax #(.FLEN(64)) dut64 (.clk(clk), .n_reset(n_reset), .bus(bus64));

  // ---------------- scoreboard ----------------
  logic [32:0] exp32_q[$];
  logic [64:0] exp64_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor for the 32-bit instance: every ready pulse consumes one expectation.
  always @(negedge clk) begin
    if (bus32.ready === 1'b1) begin
      if (exp32_q.size() == 0) begin
        n_checks++;
        $display("FAIL ready32_unexpected: got ready=1 float_out=%h required no pulse (t=%0t)",
                 bus32.float_out, $time);
      end else begin
        logic [32:0] e;
        e = exp32_q.pop_front();
        check("result32", 65'({bus32.nv, bus32.float_out}), 65'(e));
      end
    end
  end

  // Monitor for the 64-bit instance.
  always @(negedge clk) begin
    if (bus64.ready === 1'b1) begin
      if (exp64_q.size() == 0) begin
        n_checks++;
        $display("FAIL ready64_unexpected: got ready=1 float_out=%h required no pulse (t=%0t)",
                 bus64.float_out, $time);
      end else begin
        logic [64:0] e;
        e = exp64_q.pop_front();
        check("result64", {bus64.nv, bus64.float_out}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive32(input logic [5:0] ops, input logic [31:0] a, input logic [31:0] b);
    bus32.load = 1'b1;
    {bus32.op_class, bus32.op_max, bus32.op_min, bus32.op_sgnjx, bus32.op_sgnjn, bus32.op_sgnj} = ops;
    bus32.a = a;
    bus32.b = b;
  endtask

  task automatic clear32();
    bus32.load = 1'b0;
    {bus32.op_class, bus32.op_max, bus32.op_min, bus32.op_sgnjx, bus32.op_sgnjn, bus32.op_sgnj} = OP_NONE;
  endtask

  task automatic drive64(input logic [5:0] ops, input logic [63:0] a, input logic [63:0] b);
    bus64.load = 1'b1;
    {bus64.op_class, bus64.op_max, bus64.op_min, bus64.op_sgnjx, bus64.op_sgnjn, bus64.op_sgnj} = ops;
    bus64.a = a;
    bus64.b = b;
  endtask

  task automatic clear64();
    bus64.load = 1'b0;
    {bus64.op_class, bus64.op_max, bus64.op_min, bus64.op_sgnjx, bus64.op_sgnjn, bus64.op_sgnj} = OP_NONE;
  endtask

  // Single-edge op; callable back to back so load stays high across edges.
  task automatic op32(input logic [5:0] ops, input logic [31:0] a, input logic [31:0] b,
                      input logic exp_nv, input logic [31:0] exp_val);
    exp32_q.push_back({exp_nv, exp_val});
    drive32(ops, a, b);
    @(posedge clk); #1;
    clear32();
  endtask

  task automatic mm32(input logic [5:0] ops, input logic [31:0] a, input logic [31:0] b,
                      input logic exp_nv, input logic [31:0] exp_val);
    op32(ops, a, b, exp_nv, exp_val);
    @(posedge clk); #1;
  endtask

  task automatic op64(input logic [5:0] ops, input logic [63:0] a, input logic [63:0] b,
                      input logic exp_nv, input logic [63:0] exp_val);
    exp64_q.push_back({exp_nv, exp_val});
    drive64(ops, a, b);
    @(posedge clk); #1;
    clear64();
  endtask

  task automatic mm64(input logic [5:0] ops, input logic [63:0] a, input logic [63:0] b,
                      input logic exp_nv, input logic [63:0] exp_val);
    op64(ops, a, b, exp_nv, exp_val);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus32.kill = 1'b0;
    bus64.kill = 1'b0;
    bus32.a = '0; bus32.b = '0;
    bus64.a = '0; bus64.b = '0;
    clear32();
    clear64();

    #23;
    check("reset_float32", 65'(bus32.float_out), 65'(0));
    check("reset_ctrl32", 65'({bus32.nv, bus32.ready, bus32.busy}), 65'(0));
    check("reset_state32", 65'(bus32.state), 65'(IDLE));
    check("reset_float64", 65'(bus64.float_out), 65'(0));
    n_reset = 1'b1;
    @(posedge clk); #1;

    // Sign injection, back to back, including priority and NaN pass-through.
    op32(OP_SGNJX, 32'hBF80_0000, 32'h8000_0000, 1'b0, 32'h3F80_0000);
    op32(OP_SGNJ,  32'h3F80_0000, 32'h8000_0000, 1'b0, 32'hBF80_0000);
    op32(OP_SGNJN, 32'h3F80_0000, 32'h8000_0000, 1'b0, 32'h3F80_0000);
    op32(OP_SGNJN, 32'h3F80_0000, 32'h0000_0000, 1'b0, 32'hBF80_0000);
    op32(OP_SGNJ,  32'h7FC0_0001, 32'h8000_0000, 1'b0, 32'hFFC0_0001);
    op32(OP_SGNJ | OP_MIN, 32'h3F80_0000, 32'h8000_0000, 1'b0, 32'hBF80_0000);
    op32(OP_SGNJX | OP_SGNJN, 32'h3F80_0000, 32'h8000_0000, 1'b0, 32'h3F80_0000);

    // fmin(+0,-0) with busy observed between the two edges.
    exp32_q.push_back({1'b0, 32'h8000_0000});
    drive32(OP_MIN, 32'h0000_0000, 32'h8000_0000);
    @(posedge clk); #1;
    clear32();
    check("busy_in_cmp", 65'(bus32.busy), 65'(1));
    check("state_in_cmp", 65'(bus32.state), 65'(CMP));
    @(posedge clk); #1;
    check("busy_after_cmp", 65'(bus32.busy), 65'(0));

    mm32(OP_MAX, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000);
    mm32(OP_MAX, 32'h7F80_0001, 32'h3F80_0000, 1'b1, 32'h3F80_0000);
    mm32(OP_MAX, 32'h7FC0_0001, 32'h7FC0_0001, 1'b0, 32'h7FC0_0000);
    mm32(OP_MIN, 32'hC000_0000, 32'hBF80_0000, 1'b0, 32'hC000_0000);
    mm32(OP_MAX, 32'hC000_0000, 32'hBF80_0000, 1'b0, 32'hBF80_0000);
    mm32(OP_MIN, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 32'h3F80_0000);
    mm32(OP_MIN, 32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000);
    mm32(OP_MAX, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4000_0000);
    mm32(OP_MIN, 32'h7F80_0000, 32'h7F80_0001, 1'b1, 32'h7F80_0000);

    // Load with no op clears the previous result and nv.
    drive32(OP_NONE, 32'h3F80_0000, 32'h0000_0000);
    @(posedge clk); #1;
    clear32();
    check("noop_clear", 65'({bus32.nv, bus32.ready, bus32.float_out}), 65'(0));

`ifdef AIRI5C_FPU_FCLASS_EN
    op32(OP_CLASS, 32'hFF80_0000, 32'h0, 1'b0, 32'h0000_0001);
    op32(OP_CLASS, 32'h0000_0001, 32'h0, 1'b0, 32'h0000_0020);
    op32(OP_CLASS, 32'h7F80_0001, 32'h0, 1'b0, 32'h0000_0100);
    op32(OP_CLASS, 32'h8000_0000, 32'h0, 1'b0, 32'h0000_0008);
    op32(OP_CLASS, 32'h7FC0_0000, 32'h0, 1'b0, 32'h0000_0200);
`else
    op32(OP_SGNJ, 32'h3F80_0000, 32'h0, 1'b0, 32'h3F80_0000);
    drive32(OP_CLASS, 32'hFF80_0000, 32'h0);
    @(posedge clk); #1;
    clear32();
    check("class_disabled", 65'({bus32.ready, bus32.float_out}), 65'(0));
`endif

    // Kill during CMP discards the compare and clears outputs.
    op32(OP_SGNJ, 32'h4000_0000, 32'h0, 1'b0, 32'h4000_0000);
    drive32(OP_MAX, 32'h3F80_0000, 32'h0000_0000);
    @(posedge clk); #1;
    clear32();
    bus32.kill = 1'b1;
    check("busy_before_kill", 65'(bus32.busy), 65'(1));
    @(posedge clk); #1;
    bus32.kill = 1'b0;
    check("kill_outputs", 65'({bus32.nv, bus32.ready, bus32.busy, bus32.float_out}), 65'(0));
    check("kill_state", 65'(bus32.state), 65'(IDLE));
    @(posedge clk); #1;

    // A second load held into the CMP cycle is dropped.
    exp32_q.push_back({1'b0, 32'h4000_0000});
    drive32(OP_MIN, 32'h4000_0000, 32'h7F80_0000);
    @(posedge clk); #1;
    drive32(OP_SGNJ, 32'h3F80_0000, 32'h8000_0000);
    @(posedge clk); #1;
    clear32();
    @(posedge clk); #1;
    check("held_load_ignored", 65'(bus32.float_out), 65'(32'h4000_0000));

    // Asynchronous reset in the middle of a compare.
    drive32(OP_MAX, 32'h4040_0000, 32'h0000_0000);
    @(posedge clk); #1;
    clear32();
    #2 n_reset = 1'b0;
    #1;
    check("async_rst_outputs", 65'({bus32.nv, bus32.ready, bus32.busy, bus32.float_out}), 65'(0));
    check("async_rst_state", 65'(bus32.state), 65'(IDLE));
    #2 n_reset = 1'b1;
    @(posedge clk); #1;

    // Double precision.
    op64(OP_SGNJN, 64'h3FF0_0000_0000_0000, 64'h0, 1'b0, 64'hBFF0_0000_0000_0000);
    mm64(OP_MIN, 64'h7FF0_0000_0000_0001, 64'h7FF0_0000_0000_0001, 1'b1, 64'h7FF8_0000_0000_0000);
    mm64(OP_MAX, 64'h8000_0000_0000_0000, 64'h0, 1'b0, 64'h0);
    mm64(OP_MIN, 64'h7FF8_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b0, 64'hC000_0000_0000_0000);
    mm64(OP_MIN, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000);
    mm64(OP_MAX, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 64'h4000_0000_0000_0000);

    repeat (3) @(posedge clk);
    #1;
    check("drain32", 65'(exp32_q.size()), 65'(0));
    check("drain64", 65'(exp64_q.size()), 65'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/airi5c_sign_minmax.md
Name: airi5c_sign_minmax

Overview:
Parametrised FPU sign-manipulation and min/max unit for the airi5c FPU, covering FSGNJ, FSGNJN, FSGNJX, FMIN and FMAX at single or double precision.
It sits beside the other FPU execution units and uses the same load/kill/ready handshake.
Sign ops complete in 1 cycle. Min/max runs through a 2-state compare FSM and completes in 2 cycles.
It also returns the NV (invalid) exception flag.

Parameters:
FLEN, 32, operand/result width; only 32 or 64 are legal, any other value is an elaboration error.
EXP_W, derived (8 or 11), exponent width; not user-overridable.

Ports:
clk  in  1  clock
n_reset  in  1  asynchronous reset, active-low
kill  in  1  abort current operation, highest priority after reset
load  in  1  start operation; sampled only when busy=0
op_sgnj  in  1  sign inject
op_sgnjn  in  1  negated sign inject
op_sgnjx  in  1  xor sign inject
op_min  in  1  minimum
op_max  in  1  maximum
op_class  in  1  classify (see Optional Feature)
a  in  FLEN  operand A
b  in  FLEN  operand B (full word; sign is b[FLEN-1])
float_out  out  FLEN  registered result
nv  out  1  invalid-operation flag, valid while ready=1
ready  out  1  one-cycle result-valid pulse
busy  out  1  min/max compare in progress

Behaviour:
- Reset (async, n_reset=0): float_out=0, nv=0, ready=0, busy=0, state=IDLE, operand registers=0.
- States: IDLE and CMP.
- Priority per edge: reset > kill > load-with-no-op > load-with-op > default.
- kill, in any state: return to IDLE, float_out=0, nv=0, ready=0, busy=0. Any in-flight min/max is discarded and no ready pulse is produced.
- load with no op asserted, in IDLE: float_out=0, nv=0, ready=0.
- Multiple ops asserted: priority sgnj > sgnjn > sgnjx > min > max > class.
- Sign ops (IDLE+load): next edge float_out={sign, a[FLEN-2:0]}, where sign is b[FLEN-1], !b[FLEN-1] or a[FLEN-1]^b[FLEN-1]. nv=0, ready=1 for one cycle. NaNs are passed through untouched.
- min/max, first edge (IDLE+load): register a, b and the op; state=CMP; busy=1; ready=0.
- min/max, second edge (CMP): write result and nv; ready=1; busy=0; state=IDLE. Latency from load to ready is 2 edges.
- Min/max rules:
  - Ordering by sign-magnitude, with -0 < +0. fmin(+0,-0)=-0 and fmax(-0,+0)=+0.
  - Exactly one operand NaN: result is the other operand.
  - Both operands NaN: result is the canonical qNaN, 0x7FC00000 (FLEN=32) or 0x7FF8000000000000 (FLEN=64).
  - nv=1 if either operand is an sNaN (exponent all ones, mantissa nonzero, quiet bit 0). Otherwise nv=0.
- load while busy=1 is ignored; the upstream unit must hold the op. A load in the same cycle that CMP completes is also ignored.
- Default cycle (no load, no kill): ready=0. float_out and nv hold their last value.
- Back-to-back sign ops can issue every cycle and produce a ready pulse every cycle.

Optional Feature:
Macro AIRI5C_FPU_FCLASS_EN.
- Defined: op_class (IDLE+load) completes in 1 cycle. float_out = 10-bit RISC-V FCLASS one-hot of a, zero-extended to FLEN. The bits in order:
  - bit0: -inf
  - bit1: -normal
  - bit2: -subnormal
  - bit3: -0
  - bit4: +0
  - bit5: +subnormal
  - bit6: +normal
  - bit7: +inf
  - bit8: sNaN
  - bit9: qNaN
  nv=0, ready=1.
- Not defined: the op_class port still exists but is treated as no op. If op_class is the only op asserted on load: float_out=0, ready=0. Classify logic is not synthesised.

Decomposition:
- Package airi5c_fpu_pkg holds:
  - the FLEN-indexed EXP_W/mantissa-width constants
  - the canonical qNaN constants for 32 and 64
  - the FCLASS bit-position constants
  - the state enum (IDLE, CMP)
- One sub-module: airi5c_fp_classify (combinational, FLEN-parametrised). Outputs is_zero, is_sub, is_inf, is_snan, is_qnan and sign. It is instantiated twice, once for each operand, and feeds both min/max and FCLASS.

Test Plan:
1. FLEN=32, load+op_sgnjx, a=0xBF800000, b=0x80000000 -> next edge float_out=0x3F800000, ready=1 for exactly one cycle, nv=0.
2. FLEN=32, load+op_min, a=0x00000000, b=0x80000000 -> busy=1 after edge 1; after edge 2 float_out=0x80000000, ready=1, busy=0.
3. FLEN=32, op_max, a=0x7F800001 (sNaN), b=0x3F800000 -> float_out=0x3F800000, nv=1. Repeat with a=b=0x7FC00001 -> float_out=0x7FC00000, nv=0.
4. FLEN=64, op_min, a=b=0x7FF0000000000001 -> float_out=0x7FF8000000000000, nv=1.
5. Issue op_max, assert kill in the CMP cycle -> ready never pulses, float_out=0, busy=0. A second load held during CMP -> ignored. Async n_reset mid-CMP -> all outputs 0 immediately.
6. With AIRI5C_FPU_FCLASS_EN, op_class a=0xFF800000 -> float_out=0x00000001, ready=1. Without the macro, same stimulus -> float_out=0, ready=0.
